// File: rtl/reaction_pkg.sv
// reaction_pkg: shared types and default sizing for the button front end
// of the reaction game.
package reaction_pkg;

    // Press-tracking states of the button front end.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_t;

    // The game core measures reaction time in 4-bit tick counts.
    localparam int DEFAULT_HOLD_W          = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000;
    localparam int DEFAULT_TICK_DIV        = 1000;
    localparam int DEFAULT_LONG_TICKS      = 8;

endpackage

// File: rtl/button_event_tx_sync_debounce.sv
// sync_debounce: two-flop synchroniser for the raw button pin followed by a
// stability counter. The debounced level only moves after the synchronised
// input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
// settle_o is high in the cycle before the level toggles so the owning FSM
// can change state on the same edge as the level.
module sync_debounce
    import reaction_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw_i,
    output logic sync_o,
    output logic settle_o,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             differ;
    logic             settle;

    assign differ = (sync2_q != level_q);
    assign settle = differ && (cnt_q == CNT_LAST);

    // Bring the asynchronous pin into the clock domain through two flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= button_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing cycles; any agreement or a completed count restarts from zero.
    always_comb begin
        cnt_d = '0;
        if (differ && !settle) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Commit the new level and its edge strobe on the edge after the count completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_q ^ settle;
            rise_q  <= settle & ~level_q;
            fall_q  <= settle & level_q;
        end
    end

    assign sync_o   = sync2_q;
    assign settle_o = settle;
    assign level_o  = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/button_event_tx.sv
// button_event_tx: debounced push-button front end for the reaction game.
// Emits clean press/release pulses and, for every completed press, a
// hold-duration event (in saturating ticks) on a valid/ready channel.
// Build option: define LONG_PRESS_EN to add the LONG_TICKS parameter and a
// one-cycle long_press output when a hold reaches LONG_TICKS ticks.
module button_event_tx
    import reaction_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TICK_DIV        = DEFAULT_TICK_DIV,
`ifdef LONG_PRESS_EN
    parameter int LONG_TICKS      = DEFAULT_LONG_TICKS,
`endif
    parameter int HOLD_W          = DEFAULT_HOLD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              button_raw,
    output logic              button_level,
    output logic              press_pulse,
    output logic              release_pulse,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [HOLD_W-1:0] evt_ticks,
`ifdef LONG_PRESS_EN
    output logic              long_press,
`endif
    output logic              evt_overflow
);

    localparam int PRE_W = $clog2(TICK_DIV + 1);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = '1;

    btn_state_t        state_q;
    btn_state_t        state_d;
    logic              syncLevel;
    logic              settle;
    logic              enterHeld;
    logic              inHold;
    logic              issueEvt;
    logic              tickFire;
    logic              evtAccept;
    logic [PRE_W-1:0]  presc_q;
    logic [HOLD_W-1:0] holdCnt_q;
    logic              evtValid_q;
    logic [HOLD_W-1:0] evtTicks_q;
    logic              evtOverflow_q;

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk         (clk),
        .reset       (reset),
        .button_raw_i(button_raw),
        .sync_o      (syncLevel),
        .settle_o    (settle),
        .level_o     (button_level),
        .rise_o      (press_pulse),
        .fall_o      (release_pulse)
    );

    // Press-tracking state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Follow the synchronised pin; only a completed debounce count moves between IDLE and HELD.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (syncLevel) state_d = PRESS_PEND;
            end
            PRESS_PEND: begin
                if (!syncLevel)  state_d = IDLE;
                else if (settle) state_d = HELD;
            end
            HELD: begin
                if (!syncLevel) state_d = RELEASE_PEND;
            end
            RELEASE_PEND: begin
                if (syncLevel)   state_d = HELD;
                else if (settle) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Decode the state into the strobes that drive hold timing and event issue.
    always_comb begin
        enterHeld = (state_q == PRESS_PEND) && syncLevel && settle;
        inHold    = (state_q == HELD) || (state_q == RELEASE_PEND);
        issueEvt  = (state_q == RELEASE_PEND) && !syncLevel && settle;
        tickFire  = inHold && (presc_q == PRE_LAST);
        evtAccept = evtValid_q && evt_ready;
    end

    // Measure the hold in ticks of TICK_DIV cycles, restarting at each new press and saturating.
    always_ff @(posedge clk) begin
        if (reset || enterHeld) begin
            presc_q   <= '0;
            holdCnt_q <= '0;
        end else if (inHold) begin
            if (tickFire) begin
                presc_q <= '0;
                if (holdCnt_q != HOLD_MAX) begin
                    holdCnt_q <= holdCnt_q + HOLD_W'(1);
                end
            end else begin
                presc_q <= presc_q + PRE_W'(1);
            end
        end
    end

    // Load a finished press into the event slot, or drop it and flag overflow if the slot is still owned.
    always_ff @(posedge clk) begin
        if (reset) begin
            evtValid_q    <= 1'b0;
            evtTicks_q    <= '0;
            evtOverflow_q <= 1'b0;
        end else if (issueEvt) begin
            if (!evtValid_q || evtAccept) begin
                evtValid_q <= 1'b1;
                evtTicks_q <= holdCnt_q;
            end else begin
                evtOverflow_q <= 1'b1;
            end
        end else if (evtAccept) begin
            evtValid_q <= 1'b0;
        end
    end

    assign evt_valid    = evtValid_q;
    assign evt_ticks    = evtTicks_q;
    assign evt_overflow = evtOverflow_q;

`ifdef LONG_PRESS_EN
    logic longPress_q;

    // Pulse once on the tick that carries the hold count up to LONG_TICKS.
    always_ff @(posedge clk) begin
        if (reset) begin
            longPress_q <= 1'b0;
        end else begin
            longPress_q <= tickFire && (holdCnt_q != HOLD_MAX) &&
                           (32'(holdCnt_q) == 32'(LONG_TICKS - 1));
        end
    end

    assign long_press = longPress_q;
`else
    // Without long-press detection the hold count only feeds the event slot.
`endif

endmodule

// File: tb/tb_button_event_tx.sv
// tb_button_event_tx: directed bench for button_event_tx with
// DEBOUNCE_CYCLES=4, TICK_DIV=2, HOLD_W=4. Timing notes: a raw edge shows on
// button_level 6 cycles later; a level-high time of D cycles yields
// floor((D-1)/2) ticks in the event. Define LONG_PRESS_EN to cover long_press.
module tb_button_event_tx;

    logic       clk;
    logic       reset;
    logic       button_raw;
    logic       button_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_ticks;
    logic       evt_overflow;
`ifdef LONG_PRESS_EN
    logic       long_press;
`endif

    int checks   = 0;
    int failures = 0;

    button_event_tx #(
        .DEBOUNCE_CYCLES(4),
        .TICK_DIV       (2),
`ifdef LONG_PRESS_EN
        .LONG_TICKS     (8),
`endif
        .HOLD_W         (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .button_raw   (button_raw),
        .button_level (button_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_ticks    (evt_ticks),
`ifdef LONG_PRESS_EN
        .long_press   (long_press),
`endif
        .evt_overflow (evt_overflow)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic raw, input logic ready);
        button_raw = raw;
        evt_ready  = ready;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_level"},    32'(button_level),  0);
        checkOutput({tag, "_press"},    32'(press_pulse),   0);
        checkOutput({tag, "_release"},  32'(release_pulse), 0);
        checkOutput({tag, "_valid"},    32'(evt_valid),     0);
        checkOutput({tag, "_ticks"},    32'(evt_ticks),     0);
        checkOutput({tag, "_overflow"}, 32'(evt_overflow),  0);
`ifdef LONG_PRESS_EN
        checkOutput({tag, "_long"},     32'(long_press),    0);
`endif
    endtask

    initial begin
        int pulses;
        int firstAt;

        // Test 1: reset with the pin already high, then a press appears 6 cycles later.
        $display("[TB] test 1: reset and first press latency");
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0);
        waitCycles(3);
        checkAllZero("t1_reset");
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            waitCycles(1);
            checkOutput($sformatf("t1_press_c%0d", k), 32'(press_pulse), (k == 6) ? 1 : 0);
            checkOutput($sformatf("t1_level_c%0d", k), 32'(button_level), (k >= 6) ? 1 : 0);
        end

        // Return to a clean idle state.
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0);
        waitCycles(2);
        reset = 1'b0;
        waitCycles(3);

        // Test 2: a 3-cycle glitch never reaches the debounced level.
        $display("[TB] test 2: short glitch rejected");
        applyStimulus(1'b1, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            waitCycles(1);
            if (k == 3) button_raw = 1'b0;
            checkOutput($sformatf("t2_level_c%0d", k), 32'(button_level), 0);
            checkOutput($sformatf("t2_press_c%0d", k), 32'(press_pulse), 0);
        end
        checkOutput("t2_valid", 32'(evt_valid), 0);

        // Test 3: 20-cycle press with the consumer ready.
        $display("[TB] test 3: 20-cycle press");
        applyStimulus(1'b1, 1'b1);
        waitCycles(5);
        checkOutput("t3_level_pre", 32'(button_level), 0);
        checkOutput("t3_press_pre", 32'(press_pulse), 0);
        waitCycles(1);
        checkOutput("t3_level_up", 32'(button_level), 1);
        checkOutput("t3_press_up", 32'(press_pulse), 1);
        waitCycles(14);
        applyStimulus(1'b0, 1'b1);
        waitCycles(5);
        checkOutput("t3_release_pre", 32'(release_pulse), 0);
        checkOutput("t3_valid_pre", 32'(evt_valid), 0);
        waitCycles(1);
        checkOutput("t3_release", 32'(release_pulse), 1);
        checkOutput("t3_level_down", 32'(button_level), 0);
        checkOutput("t3_valid", 32'(evt_valid), 1);
        checkOutput("t3_ticks", 32'(evt_ticks), 9);
        waitCycles(1);
        checkOutput("t3_valid_gone", 32'(evt_valid), 0);
        checkOutput("t3_release_gone", 32'(release_pulse), 0);
        checkOutput("t3_overflow", 32'(evt_overflow), 0);

        // Test 4: 100-cycle press saturates the tick count.
        $display("[TB] test 4: saturating hold");
        applyStimulus(1'b1, 1'b1);
        waitCycles(100);
        applyStimulus(1'b0, 1'b1);
        waitCycles(6);
        checkOutput("t4_release", 32'(release_pulse), 1);
        checkOutput("t4_valid", 32'(evt_valid), 1);
        checkOutput("t4_ticks", 32'(evt_ticks), 15);
        waitCycles(1);
        checkOutput("t4_valid_gone", 32'(evt_valid), 0);

        // Test 5: two presses with no consumer; the second is dropped.
        $display("[TB] test 5: overflow");
        applyStimulus(1'b1, 1'b0);
        waitCycles(10);
        applyStimulus(1'b0, 1'b0);
        waitCycles(10);
        checkOutput("t5_valid1", 32'(evt_valid), 1);
        checkOutput("t5_ticks1", 32'(evt_ticks), 4);
        checkOutput("t5_overflow0", 32'(evt_overflow), 0);
        applyStimulus(1'b1, 1'b0);
        waitCycles(6);
        checkOutput("t5_press2", 32'(press_pulse), 1);
        checkOutput("t5_ticks_hold", 32'(evt_ticks), 4);
        applyStimulus(1'b0, 1'b0);
        waitCycles(6);
        checkOutput("t5_release2", 32'(release_pulse), 1);
        checkOutput("t5_valid2", 32'(evt_valid), 1);
        checkOutput("t5_ticks2", 32'(evt_ticks), 4);
        checkOutput("t5_overflow1", 32'(evt_overflow), 1);
        waitCycles(3);
        checkOutput("t5_valid_stable", 32'(evt_valid), 1);
        checkOutput("t5_ticks_stable", 32'(evt_ticks), 4);
        applyStimulus(1'b0, 1'b1);
        waitCycles(1);
        checkOutput("t5_valid_gone", 32'(evt_valid), 0);
        checkOutput("t5_overflow_sticky", 32'(evt_overflow), 1);

        // Test 6: reset in the middle of a held press emits nothing.
        $display("[TB] test 6: reset mid-hold");
        applyStimulus(1'b1, 1'b1);
        waitCycles(10);
        checkOutput("t6_level_held", 32'(button_level), 1);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1);
        waitCycles(1);
        checkAllZero("t6_reset");
        waitCycles(1);
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            waitCycles(1);
            checkOutput($sformatf("t6_release_c%0d", k), 32'(release_pulse), 0);
            checkOutput($sformatf("t6_valid_c%0d", k), 32'(evt_valid), 0);
        end

`ifdef LONG_PRESS_EN
        // Long press: a 20-cycle hold crosses 8 ticks exactly once.
        $display("[TB] long press");
        pulses  = 0;
        firstAt = 0;
        applyStimulus(1'b1, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            waitCycles(1);
            if (k == 20) button_raw = 1'b0;
            if (long_press === 1'b1) begin
                pulses++;
                if (firstAt == 0) firstAt = k;
            end
        end
        checkOutput("lp_count", 32'(pulses), 1);
        checkOutput("lp_cycle", 32'(firstAt), 22);
`else
        pulses  = 0;
        firstAt = 0;
        $display("[TB] long press not built (pulses=%0d at=%0d)", pulses, firstAt);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
